// File: rtl/eth_filter_pkg.sv
// Shared types and constants for the RX destination-address filter.
package eth_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } filt_state_e;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam int          DA_BYTES   = 6;

    // Address-class decision; the runt check is applied separately by the caller.
    function automatic logic da_accept(
        input logic [47:0] da,
        input logic [47:0] mac,
        input logic        promisc,
        input logic        bcast_en,
        input logic        mcast_en
    );
        logic is_bcast;
        is_bcast  = (da == BCAST_ADDR);
        da_accept = promisc
                  | (da == mac)
                  | (bcast_en & is_bcast)
                  | (mcast_en & da[0] & ~is_bcast);
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice: registered outputs, registered ready,
// one-cycle latency and full throughput.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_valid_r;

    // Output register refills from the skid entry first; the skid entry catches a beat while stalled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
        end else if (out_ready || !out_valid_r) begin
            if (skid_valid_r) begin
                out_data_r   <= skid_data_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else begin
                out_valid_r <= in_valid;
                if (in_valid) begin
                    out_data_r <= in_data;
                end
            end
        end else if (in_valid && !skid_valid_r) begin
            skid_data_r  <= in_data;
            skid_valid_r <= 1'b1;
        end
    end

    assign in_ready  = ~skid_valid_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// RX destination-MAC filter: decides on beat 0, then forwards or silently
// consumes the rest of the frame, and keeps accept/drop statistics.
module eth_rx_mac_filter
    import eth_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [47:0]           cfg_mac_addr,
    input  logic                  cfg_promisc,
    input  logic                  cfg_bcast_en,
    input  logic                  cfg_mcast_en,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  stat_frames_ok,
    output logic [CNT_WIDTH-1:0]  stat_frames_drop,
    output logic                  drop_pulse
);

    localparam int                   PW      = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    filt_state_e          state_r;
    logic [CNT_WIDTH-1:0] frames_ok_r;
    logic [CNT_WIDTH-1:0] frames_drop_r;
    logic                 drop_pulse_r;

    logic          accept_s;
    logic          hs_s;
    logic          idle_hs_s;
    logic          skid_valid_s;
    logic          skid_ready_s;
    logic [PW-1:0] skid_in_s;
    logic [PW-1:0] skid_out_s;

    // Beat-0 decision, input ready and which beats enter the output slice.
    always_comb begin
        accept_s = da_accept(s_axis_tdata[47:0], cfg_mac_addr, cfg_promisc,
                             cfg_bcast_en, cfg_mcast_en)
                 & (s_axis_tkeep[DA_BYTES-1:0] == {DA_BYTES{1'b1}});
        case (state_r)
            ST_IDLE: begin
                s_axis_tready = skid_ready_s;
                skid_valid_s  = s_axis_tvalid & accept_s;
            end
            ST_PASS: begin
                s_axis_tready = skid_ready_s;
                skid_valid_s  = s_axis_tvalid;
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                skid_valid_s  = 1'b0;
            end
            default: begin
                s_axis_tready = skid_ready_s;
                skid_valid_s  = 1'b0;
            end
        endcase
        hs_s      = s_axis_tvalid & s_axis_tready;
        idle_hs_s = hs_s & (state_r == ST_IDLE);
        skid_in_s = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    // Frame state machine and registered drop pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            drop_pulse_r <= 1'b0;
        end else begin
            drop_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        drop_pulse_r <= ~accept_s;
                        if (!s_axis_tlast) begin
                            state_r <= accept_s ? ST_PASS : ST_DROP;
                        end
                    end
                end
                ST_PASS, ST_DROP: begin
                    if (hs_s && s_axis_tlast) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frames_ok_r   <= {CNT_WIDTH{1'b0}};
            frames_drop_r <= {CNT_WIDTH{1'b0}};
        end else if (stat_clear) begin
            frames_ok_r   <= {CNT_WIDTH{1'b0}};
            frames_drop_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (idle_hs_s && accept_s) begin
                frames_ok_r <= frames_ok_r + CNT_ONE;
            end
            if (idle_hs_s && !accept_s) begin
                frames_drop_r <= frames_drop_r + CNT_ONE;
            end
        end
    end

    axis_skid_reg #(
        .WIDTH (PW)
    ) u_skid (
        .clock     (clock),
        .resetn    (resetn),
        .in_data   (skid_in_s),
        .in_valid  (skid_valid_s),
        .in_ready  (skid_ready_s),
        .out_data  (skid_out_s),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tdata     = skid_out_s[DATA_WIDTH-1:0];
    assign m_axis_tkeep     = skid_out_s[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast     = skid_out_s[PW-2];
    assign m_axis_tuser     = skid_out_s[PW-1];
    assign stat_frames_ok   = frames_ok_r;
    assign stat_frames_drop = frames_drop_r;
    assign drop_pulse       = drop_pulse_r;

endmodule

// File: doc/eth_rx_mac_filter.md
Name: eth_rx_mac_filter

Overview:
- Receive-side destination-address filter on the 64-bit RX AXI-Stream leaving the 10G SFP Ethernet block (rx_axis_*), in the GT user clock domain (eth_gt_user_clock).
- Inspects the destination MAC in the first beat of each frame, then passes the whole frame or silently discards it.
- Keeps accepted and dropped frame counters.
- Its output feeds the DMA/NIC logic.

Parameters:
- DATA_WIDTH, 64: AXIS data width. Must be ≥64 so the full destination address is in beat 0.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clock  in  1  GT user clock (eth_gt_user_clock). All logic is on this clock.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  frame data. Byte 0 is in [7:0].
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  bad-frame flag, valid on the last beat.
- m_axis_tdata  out  DATA_WIDTH  filtered data.
- m_axis_tkeep  out  KEEP_WIDTH  filtered byte enables.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  bad-frame flag, passed through unchanged.
- cfg_mac_addr  in  48  station address. Byte 0 (first on the wire) is in [7:0].
- cfg_promisc  in  1  accept every frame.
- cfg_bcast_en  in  1  accept DA = FF:FF:FF:FF:FF:FF.
- cfg_mcast_en  in  1  accept DA with byte0 bit0 = 1.
- stat_clear  in  1  synchronous clear of both counters.
- stat_frames_ok  out  CNT_WIDTH  count of accepted frames.
- stat_frames_drop  out  CNT_WIDTH  count of dropped frames.
- drop_pulse  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State is IDLE.
  - m_axis_tvalid=0 and the skid buffer is emptied.
  - Both counters are 0; drop_pulse=0.
  - m_axis data, keep, last and user are 0.
- FSM states: IDLE (waiting for beat 0), PASS, DROP.
- Beat 0 handshake (IDLE, s_tvalid & s_tready):
  - DA = tdata[47:0].
  - accept = cfg_promisc | (DA==cfg_mac_addr) | (cfg_bcast_en & DA==48'hFFFFFFFFFFFF) | (cfg_mcast_en & DA[0] & DA!=all-ones).
  - If tkeep[5:0] != 6'h3F (runt with a partial DA), the frame is dropped regardless of the flags.
  - Config inputs are sampled only at this handshake. A change mid-frame has no effect on the current frame.
- IDLE transitions:
  - accept & !tlast: go to PASS.
  - !accept & !tlast: go to DROP.
  - tlast (single-beat frame): stay in IDLE.
- PASS: each beat is forwarded. On the tlast handshake, go to IDLE.
- DROP: each beat is consumed and discarded. On the tlast handshake, go to IDLE.
- s_axis_tready:
  - DROP: tready = 1, so a dropped frame never stalls the input.
  - IDLE and PASS: tready = skid-buffer ready. It never depends on tdata.
- Counters:
  - stat_frames_ok increments at the beat 0 handshake of an accepted frame.
  - stat_frames_drop increments at the beat 0 handshake of a dropped frame. drop_pulse is asserted in the same cycle, registered, so it is visible the next cycle.
  - Counters wrap modulo 2^CNT_WIDTH.
  - stat_clear has priority over an increment in the same cycle.
- Output stage:
  - A 2-entry skid buffer.
  - Latency is 1 cycle from input handshake to m_axis_tvalid.
  - Sustains 1 beat per clock under continuous m_axis_tready.
  - m_axis_* stay stable while tvalid & !tready (AXIS rules).
- Frame integrity:
  - tuser is passed through unchanged.
  - A tuser=1 frame that passes the filter is forwarded, not dropped.
  - Bytes are never reordered or merged.
- Back-to-back frames: beat 0 of the next frame may arrive the cycle after tlast, with no bubble.
- Reset mid-frame: any partial output frame is lost. The first input beat after reset is treated as beat 0, so a residual tail is filtered on its first 6 bytes. This is accepted behaviour; upstream is reset together.

Decomposition:
- Shared package eth_filter_pkg:
  - Filter state enum (IDLE/PASS/DROP).
  - BCAST_ADDR = 48'hFFFFFFFFFFFF.
  - DA_BYTES = 6.
- One sub-module, axis_skid_reg: 2-entry register slice, parameterised by DATA_WIDTH+KEEP_WIDTH+2, with async active-low reset.

Test Plan:
1. cfg_mac_addr=48'h5544332211_02, frame of 8 beats with DA matching, m_tready=1 → all 8 beats appear 1 cycle later, unchanged; stat_frames_ok=1; stat_frames_drop=0.
2. Same config, DA=02:00:00:00:00:99, cfg_promisc=0, 8 beats → no m_tvalid; s_tready=1 throughout; stat_frames_drop=1; one drop_pulse.
3. Broadcast frame (DA all FF) sent twice, first with cfg_bcast_en=0 then =1 → first dropped, second forwarded. Multicast DA 01:00:5E:00:00:01 with cfg_mcast_en=1 → forwarded.
4. Single-beat frame, tlast on beat 0, tkeep=8'h07, with cfg_promisc=1 → dropped; stat_frames_drop increments; FSM back in IDLE the next cycle.
5. Back-to-back frames: accept, drop, accept, under random m_tready at 50% → output is exactly frames 1 and 3, byte-identical; no beat lost or duplicated; tuser=1 on frame 3 last beat is preserved.
6. resetn pulled low mid-PASS frame, and stat_clear asserted together with a beat 0 handshake → all outputs 0 and counters 0 immediately; after release, the next frame is filtered normally and the counter reads 1.
